// File: rtl/vospi_frame_assembler.sv
// vospi_frame_assembler: parses VoSPI packets from the master byte stream
// and emits 16-bit pixels tagged with row, column and frame markers.
module vospi_frame_assembler #(
  parameter int packet_bytes_p = 164,
  parameter int frame_packets_p = 60,
  parameter int pixels_per_packet_p = (packet_bytes_p - 4) / 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] pixel_o,
  output logic        pixel_valid_o,
  output logic [5:0]  row_o,
  output logic [6:0]  col_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic        eof_o,
  output logic        seq_err_o,
  output logic [15:0] frame_count_o
);

  typedef enum logic [2:0] {
    ID_HI,
    ID_LO,
    CRC_HI,
    CRC_LO,
    PAYLOAD,
    DROP
  } state_e;

  localparam logic [7:0] last_byte_lp = 8'(packet_bytes_p - 1);
  localparam logic [5:0] last_row_lp = 6'(frame_packets_p - 1);
  localparam logic [6:0] last_col_lp = 7'(pixels_per_packet_p - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  id_hi_q, id_hi_d;
  logic        keep_q, keep_d;
  logic [5:0]  exp_q, exp_d;
  logic [7:0]  pix_hi_q, pix_hi_d;
  logic [15:0] pixel_q, pixel_d;
  logic        pvalid_q, pvalid_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        sof_q, sof_d;
  logic        eol_q, eol_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [15:0] frames_q, frames_d;

  logic [11:0] id_w;
  logic [7:0]  pidx_w;
  logic [6:0]  col_w;

  assign id_w   = {id_hi_q, data_i};
  assign pidx_w = cnt_q - 8'd4;
  assign col_w  = pidx_w[7:1];

  // Next-state and output decode; every step is gated by valid_i.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_hi_d  = id_hi_q;
    keep_d   = keep_q;
    exp_d    = exp_q;
    pix_hi_d = pix_hi_q;
    pixel_d  = pixel_q;
    row_d    = row_q;
    col_d    = col_q;
    frames_d = frames_q;
    pvalid_d = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    if (clear_i) begin
      state_d  = ID_HI;
      cnt_d    = '0;
      id_hi_d  = '0;
      keep_d   = 1'b0;
      exp_d    = '0;
      pix_hi_d = '0;
      pixel_d  = '0;
      row_d    = '0;
      col_d    = '0;
    end else if (valid_i) begin
      cnt_d = (cnt_q == last_byte_lp) ? 8'd0 : cnt_q + 8'd1;
      unique case (state_q)
        ID_HI: begin
          id_hi_d = data_i[3:0];
          state_d = ID_LO;
        end
        ID_LO: begin
          state_d = CRC_HI;
          if (id_hi_q == 4'hF) begin
            keep_d = 1'b0;
          end else if (id_w == {6'd0, exp_q}) begin
            keep_d = 1'b1;
          end else if (id_w == 12'd0) begin
            err_d  = 1'b1;
            exp_d  = '0;
            keep_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            exp_d  = '0;
            keep_d = 1'b0;
          end
        end
        CRC_HI: state_d = CRC_LO;
        CRC_LO: state_d = keep_q ? PAYLOAD : DROP;
        PAYLOAD: begin
          if (!pidx_w[0]) begin
            pix_hi_d = data_i;
          end else begin
            pixel_d  = {pix_hi_q, data_i};
            pvalid_d = 1'b1;
            row_d    = exp_q;
            col_d    = col_w;
            sof_d    = (exp_q == 6'd0) && (col_w == 7'd0);
            eol_d    = (col_w == last_col_lp);
            eof_d    = (col_w == last_col_lp) &&
                       (exp_q == last_row_lp);
          end
          if (cnt_q == last_byte_lp) begin
            state_d = ID_HI;
            if (exp_q == last_row_lp) begin
              exp_d    = '0;
              frames_d = frames_q + 16'd1;
            end else begin
              exp_d = exp_q + 6'd1;
            end
          end
        end
        DROP: begin
          if (cnt_q == last_byte_lp) state_d = ID_HI;
        end
        default: state_d = ID_HI;
      endcase
    end
  end

  // State and registered outputs; frame count survives clear_i only.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ID_HI;
      cnt_q    <= '0;
      id_hi_q  <= '0;
      keep_q   <= 1'b0;
      exp_q    <= '0;
      pix_hi_q <= '0;
      pixel_q  <= '0;
      pvalid_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_hi_q  <= id_hi_d;
      keep_q   <= keep_d;
      exp_q    <= exp_d;
      pix_hi_q <= pix_hi_d;
      pixel_q  <= pixel_d;
      pvalid_q <= pvalid_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      frames_q <= frames_d;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pvalid_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign sof_o         = sof_q;
  assign eol_o         = eol_q;
  assign eof_o         = eof_q;
  assign seq_err_o     = err_q;
  assign frame_count_o = frames_q;

endmodule

// File: tb/tb_vospi_frame_assembler.sv
// tb_vospi_frame_assembler: random-gap packet driver with a packet-level
// reference model and a pixel scoreboard.
module tb_vospi_frame_assembler;

  logic        clk_i;
  logic        reset_ni;
  logic        clear_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] pixel_o;
  logic        pixel_valid_o;
  logic [5:0]  row_o;
  logic [6:0]  col_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;
  logic        seq_err_o;
  logic [15:0] frame_count_o;

  vospi_frame_assembler dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .clear_i(clear_i),
    .data_i(data_i),
    .valid_i(valid_i),
    .pixel_o(pixel_o),
    .pixel_valid_o(pixel_valid_o),
    .row_o(row_o),
    .col_o(col_o),
    .sof_o(sof_o),
    .eol_o(eol_o),
    .eof_o(eof_o),
    .seq_err_o(seq_err_o),
    .frame_count_o(frame_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] pix;
    logic [5:0]  row;
    logic [6:0]  col;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [15:0] frames;
  } px_t;

  px_t expq[$];
  px_t mr;

  int checks = 0;
  int failures = 0;

  int m_exp = 0;
  int m_frames = 0;
  int m_errs = 0;
  bit m_last_err = 0;

  int seen_pix = 0;
  int seen_eof = 0;
  int seen_errs = 0;
  logic [15:0] sof_pix = '0;

  // Reference model: classify one packet, queue the pixels it should yield.
  task automatic model_packet(input logic [15:0] id, input int nbytes,
                              input logic [7:0] b [164]);
    bit acc;
    px_t p;
    m_last_err = 0;
    if (nbytes < 2) return;
    if (id[11:8] == 4'hF) acc = 0;
    else if (int'(id[11:0]) == m_exp) acc = 1;
    else if (id[11:0] == 12'd0) begin
      m_errs++; m_last_err = 1; m_exp = 0; acc = 1;
    end else begin
      m_errs++; m_last_err = 1; m_exp = 0; acc = 0;
    end
    if (!acc) return;
    for (int i = 0; i < 80; i++) begin
      if (5 + 2 * i < nbytes) begin
        p.pix = {b[4 + 2 * i], b[5 + 2 * i]};
        p.row = 6'(m_exp);
        p.col = 7'(i);
        p.sof = (m_exp == 0) && (i == 0);
        p.eol = (i == 79);
        p.eof = (i == 79) && (m_exp == 59);
        p.frames = 16'(m_frames + (p.eof ? 1 : 0));
        expq.push_back(p);
      end
    end
    if (nbytes == 164) begin
      if (m_exp == 59) begin
        m_exp = 0;
        m_frames++;
      end else begin
        m_exp++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    data_i = v;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // mode 0: zero payload, 1: ramp k[7:0], 2: random.
  task automatic send_packet(input logic [15:0] id, input int nbytes,
                             input int mode);
    logic [7:0] b [164];
    b[0] = id[15:8];
    b[1] = id[7:0];
    b[2] = 8'($urandom);
    b[3] = 8'($urandom);
    for (int k = 0; k < 160; k++)
      b[4 + k] = (mode == 0) ? 8'h00 :
                 (mode == 1) ? k[7:0] : 8'($urandom);
    model_packet(id, nbytes, b);
    for (int j = 0; j < nbytes; j++) begin
      send_byte(b[j]);
      if (j == 1) begin
        checks++;
        if (seq_err_o !== m_last_err) begin
          failures++;
          $display("FAIL seq_err_timing id=%h got=%b req=%b",
                   id, seq_err_o, m_last_err);
        end
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  // Pixel scoreboard and marker sanity, sampled away from the clock edge.
  always @(negedge clk_i) begin
    if (pixel_valid_o) begin
      seen_pix++;
      if (sof_o) sof_pix = pixel_o;
      if (eof_o) seen_eof++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL pixel_extra got pix=%h row=%0d col=%0d req=none",
                 pixel_o, row_o, col_o);
      end else begin
        mr = expq.pop_front();
        if (pixel_o !== mr.pix || row_o !== mr.row || col_o !== mr.col ||
            sof_o !== mr.sof || eol_o !== mr.eol || eof_o !== mr.eof ||
            frame_count_o !== mr.frames) begin
          failures++;
          $display("FAIL pixel got %h r%0d c%0d s%b l%b f%b fc%0d req %h r%0d c%0d s%b l%b f%b fc%0d",
                   pixel_o, row_o, col_o, sof_o, eol_o, eof_o,
                   frame_count_o, mr.pix, mr.row, mr.col, mr.sof,
                   mr.eol, mr.eof, mr.frames);
        end
      end
    end
    if (seq_err_o) seen_errs++;
    checks++;
    if (!pixel_valid_o && (sof_o || eol_o || eof_o)) begin
      failures++;
      $display("FAIL marker_no_valid got s%b l%b f%b req 000",
               sof_o, eol_o, eof_o);
    end
  end

  task automatic test_reset();
    reset_ni = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    data_i = 8'h00;
    idle(3);
    reset_ni = 1'b1;
    idle(2);
    checks++;
    if (pixel_o !== 16'h0 || pixel_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_pixel got %h/%b req 0000/0",
               pixel_o, pixel_valid_o);
    end
    checks++;
    if (row_o !== 6'd0 || col_o !== 7'd0) begin
      failures++;
      $display("FAIL reset_rowcol got %0d/%0d req 0/0", row_o, col_o);
    end
    checks++;
    if ({sof_o, eol_o, eof_o, seq_err_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got %b req 0000",
               {sof_o, eol_o, eof_o, seq_err_o});
    end
    checks++;
    if (frame_count_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_frames got %0d req 0", frame_count_o);
    end
  endtask

  task automatic test_discard();
    int p0 = seen_pix;
    int e0 = seen_errs;
    send_packet(16'h0F00, 164, 0);
    idle(3);
    checks++;
    if (seen_pix != p0) begin
      failures++;
      $display("FAIL discard_pixels got %0d req 0", seen_pix - p0);
    end
    checks++;
    if (seen_errs != e0) begin
      failures++;
      $display("FAIL discard_err got %0d req 0", seen_errs - e0);
    end
    checks++;
    if (frame_count_o !== 16'd0) begin
      failures++;
      $display("FAIL discard_frames got %0d req 0", frame_count_o);
    end
  endtask

  task automatic test_full_frame();
    int p0 = seen_pix;
    int f0 = seen_eof;
    for (int r = 0; r < 60; r++) send_packet(16'(r), 164, 1);
    idle(3);
    checks++;
    if (seen_pix - p0 != 4800) begin
      failures++;
      $display("FAIL frame_pixels got %0d req 4800", seen_pix - p0);
    end
    checks++;
    if (sof_pix !== 16'h0001) begin
      failures++;
      $display("FAIL frame_first_pixel got %h req 0001", sof_pix);
    end
    checks++;
    if (seen_eof - f0 != 1) begin
      failures++;
      $display("FAIL frame_eof got %0d req 1", seen_eof - f0);
    end
    checks++;
    if (frame_count_o !== 16'd1) begin
      failures++;
      $display("FAIL frame_count got %0d req 1", frame_count_o);
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL frame_missing got %0d req 0", expq.size());
    end
  endtask

  task automatic test_overrun();
    int p0 = seen_pix;
    int e0 = seen_errs;
    for (int r = 0; r < 80; r++) send_packet(16'(r), 164, 2);
    idle(3);
    checks++;
    if (seen_pix - p0 != 4800) begin
      failures++;
      $display("FAIL overrun_pixels got %0d req 4800", seen_pix - p0);
    end
    checks++;
    if (seen_errs - e0 != 20) begin
      failures++;
      $display("FAIL overrun_errs got %0d req 20", seen_errs - e0);
    end
    checks++;
    if (frame_count_o !== 16'(m_frames)) begin
      failures++;
      $display("FAIL overrun_frames got %0d req %0d",
               frame_count_o, m_frames);
    end
  endtask

  task automatic test_interleave();
    int p0 = seen_pix;
    int e0 = seen_errs;
    int fc0 = m_frames;
    for (int r = 0; r < 10; r++) send_packet(16'(r), 164, 2);
    for (int d = 0; d < 3; d++) send_packet(16'h0F00, 164, 2);
    for (int r = 10; r < 60; r++) send_packet(16'(r), 164, 2);
    idle(3);
    checks++;
    if (seen_pix - p0 != 4800 || seen_errs != e0) begin
      failures++;
      $display("FAIL interleave got pix=%0d err=%0d req 4800/0",
               seen_pix - p0, seen_errs - e0);
    end
    checks++;
    if (frame_count_o !== 16'(fc0 + 1)) begin
      failures++;
      $display("FAIL interleave_frames got %0d req %0d",
               frame_count_o, fc0 + 1);
    end
  endtask

  task automatic test_seq_gap();
    int p0 = seen_pix;
    int e0 = seen_errs;
    send_packet(16'd0, 164, 2);
    send_packet(16'd1, 164, 2);
    send_packet(16'd2, 164, 2);
    send_packet(16'd5, 164, 2);
    send_packet(16'd0, 164, 2);
    idle(3);
    checks++;
    if (seen_errs - e0 != 1) begin
      failures++;
      $display("FAIL gap_errs got %0d req 1", seen_errs - e0);
    end
    checks++;
    if (seen_pix - p0 != 320) begin
      failures++;
      $display("FAIL gap_pixels got %0d req 320", seen_pix - p0);
    end
    checks++;
    if (seen_errs != m_errs || expq.size() != 0) begin
      failures++;
      $display("FAIL gap_model got err=%0d left=%0d req %0d/0",
               seen_errs, expq.size(), m_errs);
    end
  endtask

  task automatic test_clear_reset();
    int e0 = seen_errs;
    int p0 = seen_pix;
    send_packet(16'd1, 64, 2);
    idle(2);
    clear_i = 1'b1;
    valid_i = 1'b1;
    data_i = 8'h55;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    valid_i = 1'b0;
    m_exp = 0;
    checks++;
    if (pixel_o !== 16'h0 || row_o !== 6'd0 || col_o !== 7'd0 ||
        pixel_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL clear_outputs got %h r%0d c%0d v%b req 0",
               pixel_o, row_o, col_o, pixel_valid_o);
    end
    checks++;
    if (frame_count_o !== 16'(m_frames)) begin
      failures++;
      $display("FAIL clear_frames got %0d req %0d",
               frame_count_o, m_frames);
    end
    send_packet(16'd0, 164, 2);
    idle(3);
    checks++;
    if (seen_errs != e0 || seen_pix - p0 != 110) begin
      failures++;
      $display("FAIL clear_restart got err=%0d pix=%0d req 0/110",
               seen_errs - e0, seen_pix - p0);
    end
    send_packet(16'd1, 100, 2);
    idle(2);
    #2;
    reset_ni = 1'b0;
    #1;
    m_exp = 0;
    m_frames = 0;
    checks++;
    if (pixel_o !== 16'h0 || row_o !== 6'd0 || col_o !== 7'd0 ||
        frame_count_o !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got %h r%0d c%0d fc%0d req 0",
               pixel_o, row_o, col_o, frame_count_o);
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL reset_pending got %0d req 0", expq.size());
    end
    idle(2);
    reset_ni = 1'b1;
    idle(1);
    e0 = seen_errs;
    p0 = seen_pix;
    send_packet(16'd0, 164, 2);
    idle(3);
    checks++;
    if (seen_errs != e0 || seen_pix - p0 != 80 ||
        frame_count_o !== 16'd0) begin
      failures++;
      $display("FAIL reset_restart got err=%0d pix=%0d fc=%0d req 0/80/0",
               seen_errs - e0, seen_pix - p0, frame_count_o);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout req completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_discard();
    test_full_frame();
    test_overrun();
    test_interleave();
    test_seq_gap();
    test_clear_reset();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL final_pending got %0d req 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vospi_frame_assembler.md
Name: vospi_frame_assembler

Overview:
- Sits directly downstream of vospi_master and consumes its data_o/valid_o byte stream.
- Parses each 164-byte VoSPI packet: 2-byte ID, 2-byte CRC, 160-byte payload.
- Drops discard packets and checks packet-number sequencing.
- Emits a 16-bit pixel stream tagged with row, column and frame/line markers for the display/buffer stage.
- The SPI side cannot stall, so there is no backpressure.

Parameters:
- packet_bytes_p, 164, bytes per packet including the 4-byte header.
- frame_packets_p, 60, valid packets (rows) per frame.
- pixels_per_packet_p, (packet_bytes_p-4)/2 = 80, pixels per packet.

Ports:
- clk_i, input, 1, clock; same clock as vospi_master.
- reset_ni, input, 1, asynchronous active-low reset.
- clear_i, input, 1, synchronous parser restart; pulsed when the master resyncs.
- data_i, input, 8, byte from vospi_master data_o.
- valid_i, input, 1, byte strobe from vospi_master valid_o; single-cycle, arbitrary gaps.
- pixel_o, output, 16, pixel value as {first payload byte, second payload byte}.
- pixel_valid_o, output, 1, pixel strobe.
- row_o, output, 6, packet number of the current pixel.
- col_o, output, 7, pixel index within the packet, 0..79.
- sof_o, output, 1, high with row 0 / col 0 pixel.
- eol_o, output, 1, high with col 79 pixel.
- eof_o, output, 1, high with the last pixel of row frame_packets_p-1.
- seq_err_o, output, 1, one-cycle pulse on a sequence violation.
- frame_count_o, output, 16, completed frames; wraps at 0xFFFF->0.

Behaviour:
- Reset (reset_ni low, async): all outputs 0, state ID_HI, byte counter 0, expected packet exp_r = 0.
- clear_i: same effect as reset, applied synchronously. frame_count_o is NOT cleared. clear_i has priority over a coincident valid_i.
- All state advances only on valid_i; without valid_i, state and outputs hold, and strobes drop to 0.
- FSM sequence: ID_HI -> ID_LO -> CRC_HI -> CRC_LO -> PAYLOAD or DROP. Byte counter counts 0..packet_bytes_p-1; at the last byte, return to ID_HI.
- CRC bytes are ignored (no checking).
- Packet classification, decided at ID_LO with id = {id_hi, data_i}:
  - Discard: id[11:8] == 4'hF. Packet goes to DROP. No output, no error, exp_r unchanged.
  - Accept: id[11:0] == exp_r. Packet goes to PAYLOAD.
  - Resync: id[11:0] == 0 and exp_r != 0. Pulse seq_err_o, set exp_r = 0, and accept the packet as row 0 (PAYLOAD).
  - Otherwise: mismatch, or id[11:0] >= frame_packets_p. Pulse seq_err_o, set exp_r = 0, go to DROP.
- seq_err_o pulses the cycle after the ID_LO byte is accepted.
- PAYLOAD:
  - Even payload byte latches the high byte.
  - Odd payload byte produces a pixel: pixel_valid_o = 1 on the next cycle (latency 1 clk after valid_i), together with pixel_o, row_o = exp_r, col_o = pixel index and the markers.
- After the last payload byte of an accepted packet:
  - If exp_r == frame_packets_p-1: exp_r = 0 and frame_count_o += 1, updating in the same cycle as eof_o.
  - Otherwise: exp_r += 1.
- sof_o, eol_o and eof_o are only ever high when pixel_valid_o is high.
- A new frame starts only at packet 0; packets arriving after a completed frame must restart at 0.

Test Plan:
- Reset, then a discard packet (ID 0x0F00, 160 zero bytes) -> no pixel_valid_o, seq_err_o stays 0, frame_count_o = 0.
- Frame of packets 0..59 with payload byte k = k[7:0] -> 4800 pixels, first pixel 0x0001 with sof_o; each row ends with col_o = 79 and eol_o; the last pixel carries eof_o; frame_count_o = 1.
- Frame of packets 0..79 -> rows 0..59 emitted and frame_count_o = 1 after packet 59. Packet 60 -> seq_err_o pulse, no pixels. Packets 61..79 -> one seq_err_o each, all dropped.
- Packets 0,1,2 then 5 -> seq_err_o once, packet 5 dropped. Next packet 0 accepted with sof_o, no extra error.
- Packets 0..9, then discards 0x0F00 x3, then 10..59 -> discards invisible, full frame completes, frame_count_o increments once.
- Mid-payload clear_i pulse and mid-packet reset_ni pulse -> outputs 0 immediately (async for reset); the next ID 0x0000 is parsed as a fresh row 0. frame_count_o is preserved on clear_i and zeroed on reset_ni.
